// File: rtl/block_ram.sv
// block_ram: single-port synchronous RAM with read-first registered output.
// One address per cycle serves both the read and the write. o_data is a
// registered copy of the addressed word (pre-write value on write cycles).
// Out-of-range addresses neither write nor read; they return zeros.
module block_ram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  w_e,
  output logic [DATA_WIDTH-1:0] o_data
);

  // Storage array. The declaration initialiser gives all-zero contents at
  // power-up in simulation and as the FPGA init image.
  logic [DATA_WIDTH-1:0] sram [0:DEPTH-1] = '{default: '0};

  // Registered read data, zero at power-up.
  logic [DATA_WIDTH-1:0] rd_q = '0;

  // Address qualifies for array access only below DEPTH.
  logic in_range_c;

  // Range check on the shared address.
  assign in_range_c = (32'(addr) < 32'(DEPTH));

  // Write port: no reset, so contents persist through reset and writes
  // presented during reset still land.
  always_ff @(posedge clk) begin
    if (w_e && in_range_c) begin
      sram[addr] <= i_data;
    end
  end

  // Read port: synchronous read, read-first; reset clears only the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (in_range_c) begin
      rd_q <= sram[addr];
    end else begin
      rd_q <= '0;
    end
  end

  assign o_data = rd_q;

endmodule

// File: tb/tb_block_ram.sv
// tb_block_ram: directed stimulus with a queue-based scoreboard for two
// block_ram instances (default 512-deep and a 500-deep variant).
module tb_block_ram;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 128;

  typedef struct {
    logic [DW-1:0] exp;
    int            tag;
  } sb_entry_t;

  logic          clk = 1'b0;
  // Instance A: DEPTH 512
  logic          reset_a = 1'b0;
  logic [AW-1:0] addr_a  = '0;
  logic [DW-1:0] data_a  = '0;
  logic          we_a    = 1'b0;
  logic [DW-1:0] odata_a;
  // Instance B: DEPTH 500
  logic          reset_b = 1'b0;
  logic [AW-1:0] addr_b  = '0;
  logic [DW-1:0] data_b  = '0;
  logic          we_b    = 1'b0;
  logic [DW-1:0] odata_b;

  logic chk_a = 1'b0, chk_b = 1'b0;
  logic chk_a_q = 1'b0, chk_b_q = 1'b0;

  sb_entry_t q_a[$];
  sb_entry_t q_b[$];

  int compared   = 0;
  int mismatched = 0;
  int tag_cnt    = 0;

  localparam logic [DW-1:0] P11  = {16{8'h11}};
  localparam logic [DW-1:0] P22  = {16{8'h22}};
  localparam logic [DW-1:0] P33  = {16{8'h33}};
  localparam logic [DW-1:0] PAA  = {16{8'hAA}};
  localparam logic [DW-1:0] PBB  = {16{8'hBB}};
  localparam logic [DW-1:0] CAFE = 128'hCAFE;
  localparam logic [DW-1:0] P55  = 128'h55;
  localparam logic [DW-1:0] PFF  = 128'hFF;
  localparam logic [DW-1:0] P77  = {16{8'h77}};

  block_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(512)) u_ram_a (
    .clk    (clk),
    .reset  (reset_a),
    .addr   (addr_a),
    .i_data (data_a),
    .w_e    (we_a),
    .o_data (odata_a)
  );

  block_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(500)) u_ram_b (
    .clk    (clk),
    .reset  (reset_b),
    .addr   (addr_b),
    .i_data (data_b),
    .w_e    (we_b),
    .o_data (odata_b)
  );

  always #5 clk = ~clk;

  // Mark which issued cycles carry an expectation once the edge consumes them.
  always @(posedge clk) begin
    chk_a_q <= chk_a;
    chk_b_q <= chk_b;
  end

  // Monitor: on the falling edge, compare each DUT output that has a pending
  // expectation against the head of its queue.
  always @(negedge clk) begin
    sb_entry_t e;
    if (chk_a_q) begin
      compared++;
      if (q_a.size() == 0) begin
        mismatched++;
        $display("FAIL ram_a no_expectation got %h", odata_a);
      end else begin
        e = q_a.pop_front();
        if (odata_a !== e.exp) begin
          mismatched++;
          $display("FAIL ram_a chk%0d got %h exp %h", e.tag, odata_a, e.exp);
        end
      end
    end
    if (chk_b_q) begin
      compared++;
      if (q_b.size() == 0) begin
        mismatched++;
        $display("FAIL ram_b no_expectation got %h", odata_b);
      end else begin
        e = q_b.pop_front();
        if (odata_b !== e.exp) begin
          mismatched++;
          $display("FAIL ram_b chk%0d got %h exp %h", e.tag, odata_b, e.exp);
        end
      end
    end
  end

  // Drive one cycle on instance sel (0=A, 1=B); the other idles. When chk is
  // set, exp is the o_data value required after this cycle's rising edge.
  task automatic issue(input bit sel, input bit rst, input bit we,
                       input int unsigned a, input logic [DW-1:0] d,
                       input bit chk, input logic [DW-1:0] exp);
    sb_entry_t e;
    @(negedge clk);
    reset_a = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0; chk_a = 1'b0;
    reset_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0; chk_b = 1'b0;
    e.exp = exp;
    e.tag = tag_cnt;
    if (chk) tag_cnt++;
    if (!sel) begin
      reset_a = rst; we_a = we; addr_a = AW'(a); data_a = d; chk_a = chk;
      if (chk) q_a.push_back(e);
    end else begin
      reset_b = rst; we_b = we; addr_b = AW'(a); data_b = d; chk_b = chk;
      if (chk) q_b.push_back(e);
    end
  endtask

  initial begin
    // Power-up value before any edge or reset.
    #1;
    compared++;
    if (odata_a !== '0) begin
      mismatched++;
      $display("FAIL powerup_a got %h exp 0", odata_a);
    end
    compared++;
    if (odata_b !== '0) begin
      mismatched++;
      $display("FAIL powerup_b got %h exp 0", odata_b);
    end

    // Unwritten array reads zero everywhere.
    for (int i = 0; i < 512; i++) issue(0, 0, 0, i, '0, 1, '0);

    // Reset cycle clears o_data.
    issue(0, 1, 0, 0, '0, 1, '0);

    // Write/readback at 0, 1 and the top word; write cycles return old zeros.
    issue(0, 0, 1, 0,   P11, 1, '0);
    issue(0, 0, 1, 1,   P22, 1, '0);
    issue(0, 0, 1, 511, P33, 1, '0);
    issue(0, 0, 0, 0,   '0,  1, P11);
    issue(0, 0, 0, 1,   '0,  1, P22);
    issue(0, 0, 0, 511, '0,  1, P33);

    // Read-first: overwrite returns the previous word.
    issue(0, 0, 1, 5, PAA, 1, '0);
    issue(0, 0, 1, 5, PBB, 1, PAA);
    issue(0, 0, 0, 5, '0,  1, PBB);
    // Write cycle output tracks the write address, not the prior read.
    issue(0, 0, 0, 1, '0,  1, P22);
    issue(0, 0, 1, 0, P77, 1, P11);
    issue(0, 0, 0, 0, '0,  1, P77);

    // Reset clears o_data but not the array.
    issue(0, 0, 1, 7, CAFE, 1, '0);
    issue(0, 0, 0, 7, '0,   1, CAFE);
    issue(0, 1, 0, 7, '0,   1, '0);
    issue(0, 0, 0, 7, '0,   1, CAFE);

    // Write presented during reset is still performed.
    issue(0, 1, 1, 3, P55, 1, '0);
    issue(0, 0, 0, 3, '0,  1, P55);
    issue(0, 0, 0, 5, '0,  1, PBB);

    // 500-deep instance: out-of-range write ignored, reads return zero.
    issue(1, 0, 1, 505, PFF, 1, '0);
    issue(1, 0, 0, 505, '0,  1, '0);
    issue(1, 0, 0, 500, '0,  1, '0);
    issue(1, 0, 0, 511, '0,  1, '0);
    for (int i = 0; i < 500; i++) issue(1, 0, 0, i, '0, 1, '0);
    // Top valid word works; address just past it still reads zero.
    issue(1, 0, 1, 499, P77, 1, '0);
    issue(1, 0, 0, 499, '0,  1, P77);
    issue(1, 0, 0, 500, '0,  1, '0);
    // Stale non-zero register must clear on an out-of-range read.
    issue(1, 0, 0, 499, '0,  1, P77);
    issue(1, 0, 0, 505, '0,  1, '0);

    // Drain: idle cycles so the last expectations are consumed.
    issue(0, 0, 0, 0, '0, 0, '0);
    @(negedge clk);
    @(negedge clk);

    compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain left a=%0d b=%0d exp 0", q_a.size(), q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout reached sim time %0t", $time);
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
